// File: rtl/axis_pkt_checker.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_checker
// Purpose  : Receive-side AXI-Stream checker for the packet generator stream.
//            Validates the UDP length field of each header beat, the per-packet
//            sequence number carried by body beats, tkeep on body beats and
//            tlast framing. Keeps packet, byte and error statistics.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            s_axis_*           - 512-bit AXIS slave (tdata/tkeep/tvalid/
//                                 tready/tlast)
//            cfg_enable         - 1 = accept and check, 0 = hold tready low
//            cfg_pkt_len        - expected beats per packet (0 treated as 1)
//            pkt_count          - packets accepted (tlast beats)
//            byte_count         - sum of popcount(tkeep) over accepted beats
//            err_count          - number of error codes raised (wraps)
//            err_flag           - sticky error indicator
//            last_err_code      - highest code raised on the latest bad beat
//            last_flow_id       - byte 35 of the latest accepted header beat
// Options  : define AXIS_PKT_CHECKER_BACKPRESSURE_EN to gate tready with a
//            16-bit LFSR (~78% ready duty) to exercise upstream backpressure.
// Error codes: 1 length field, 2 sequence jump (resync), 3 payload mismatch,
//            4 tkeep not all-ones, 5 early tlast, 6 missing tlast.
// Revision : 1.0 - initial release
// ============================================================================
module axis_pkt_checker #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int CNT_WIDTH       = 64,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic                       cfg_enable,
  input  logic [LEN_WIDTH-1:0]       cfg_pkt_len,
  output logic [CNT_WIDTH-1:0]       pkt_count,
  output logic [CNT_WIDTH-1:0]       byte_count,
  output logic [CNT_WIDTH-1:0]       err_count,
  output logic                       err_flag,
  output logic [2:0]                 last_err_code,
  output logic [7:0]                 last_flow_id
);

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_BODY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [LEN_WIDTH-1:0] beat_idx, beat_idx_n;
  logic [LEN_WIDTH-1:0] len_q, len_q_n;
  logic [LEN_WIDTH-1:0] len_cur;
  logic [LEN_WIDTH-1:0] last_idx;
  logic [CNT_WIDTH-1:0] exp_seq, exp_seq_n;
  logic [CNT_WIDTH-1:0] seq_base;
  logic [CNT_WIDTH-1:0] exp_val;
  logic [CNT_WIDTH-1:0] rx_word;
  logic                 seq_locked, seq_locked_n;
  logic                 ready_q;
  logic                 accept;
  logic                 pkt_end;
  logic                 data_match;
  logic [15:0]          hdr_len_field;
  logic [15:0]          hdr_len_exp;
  logic [6:1]           err;
  logic [2:0]           err_num;
  logic [2:0]           err_code;

  function automatic logic [CNT_WIDTH-1:0] popcnt_keep(input logic [AXIS_KEEP_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] s;
    s = '0;
    for (int b = 0; b < AXIS_KEEP_WIDTH; b++) begin
      s = s + CNT_WIDTH'(v[b]);
    end
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Ready generation (registered)
  // --------------------------------------------------------------------------
`ifdef AXIS_PKT_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr    <= 16'hACE1;
      ready_q <= 1'b0;
    end else begin
      lfsr    <= {lfsr[14:0], lfsr_fb};
      ready_q <= cfg_enable && (lfsr[6:0] < 7'd100);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= cfg_enable;
    end
  end
`endif

  assign s_axis_tready = ready_q;
  assign accept        = s_axis_tvalid && ready_q;

  // --------------------------------------------------------------------------
  // Datapath helpers
  // --------------------------------------------------------------------------
  assign len_cur       = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
  // Length field is big-endian: byte 16 is the MSB.
  assign hdr_len_field = {s_axis_tdata[16*8 +: 8], s_axis_tdata[17*8 +: 8]};
  assign hdr_len_exp   = (16'(len_cur) << 6) - 16'd14;
  assign last_idx      = len_q - LEN_WIDTH'(1);
  assign exp_val       = exp_seq + CNT_WIDTH'(beat_idx);
  assign rx_word       = s_axis_tdata[CNT_WIDTH-1:0];
  // Expected payload is the sequence value zero-extended to the full beat.
  assign data_match    = (s_axis_tdata ==
                          {{(AXIS_DATA_WIDTH-CNT_WIDTH){1'b0}}, exp_val});

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HDR;
      beat_idx   <= '0;
      len_q      <= LEN_WIDTH'(1);
      exp_seq    <= CNT_WIDTH'(1);
      seq_locked <= 1'b0;
    end else begin
      state      <= state_n;
      beat_idx   <= beat_idx_n;
      len_q      <= len_q_n;
      exp_seq    <= exp_seq_n;
      seq_locked <= seq_locked_n;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and error decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_n      = state;
    beat_idx_n   = beat_idx;
    len_q_n      = len_q;
    seq_locked_n = seq_locked;
    seq_base     = exp_seq;
    err          = '0;
    pkt_end      = 1'b0;

    if (accept) begin
      case (state)
        ST_HDR: begin
          len_q_n = len_cur;
          if (hdr_len_field != hdr_len_exp) err[1] = 1'b1;
          if (len_cur == LEN_WIDTH'(1)) begin
            if (s_axis_tlast) begin
              pkt_end = 1'b1;
            end else begin
              err[6]  = 1'b1;
              state_n = ST_DRAIN;
            end
          end else if (s_axis_tlast) begin
            err[5]  = 1'b1;
            pkt_end = 1'b1;
          end else begin
            state_n    = ST_BODY;
            beat_idx_n = LEN_WIDTH'(1);
          end
        end

        ST_BODY: begin
          if (beat_idx == LEN_WIDTH'(1)) begin
            // The first body beat either establishes the sequence or, once
            // locked, re-synchronises it after a gap.
            if (!seq_locked) begin
              seq_base     = rx_word - CNT_WIDTH'(1);
              seq_locked_n = 1'b1;
            end else if (!data_match) begin
              err[2]   = 1'b1;
              seq_base = rx_word - CNT_WIDTH'(1);
            end
          end else if (!data_match) begin
            err[3] = 1'b1;
          end

          if (s_axis_tkeep != {AXIS_KEEP_WIDTH{1'b1}}) err[4] = 1'b1;

          if (beat_idx != last_idx) begin
            if (s_axis_tlast) begin
              err[5]  = 1'b1;
              pkt_end = 1'b1;
              state_n = ST_HDR;
            end else begin
              beat_idx_n = beat_idx + LEN_WIDTH'(1);
            end
          end else if (s_axis_tlast) begin
            pkt_end = 1'b1;
            state_n = ST_HDR;
          end else begin
            err[6]  = 1'b1;
            state_n = ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (s_axis_tlast) begin
            pkt_end = 1'b1;
            state_n = ST_HDR;
          end
        end

        default: begin
          state_n = ST_HDR;
        end
      endcase
    end

    // Sequence advance is applied on top of any resync from the same packet.
    exp_seq_n = pkt_end ? (seq_base + CNT_WIDTH'(1)) : seq_base;
    if (pkt_end) beat_idx_n = '0;
  end

  always_comb begin
    err_num  = '0;
    err_code = '0;
    for (int c = 1; c <= 6; c++) begin
      err_num = err_num + 3'(err[c]);
      if (err[c]) err_code = 3'(c);
    end
  end

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count     <= '0;
      byte_count    <= '0;
      err_count     <= '0;
      err_flag      <= 1'b0;
      last_err_code <= '0;
      last_flow_id  <= '0;
    end else if (accept) begin
      byte_count <= byte_count + popcnt_keep(s_axis_tkeep);
      if (pkt_end) pkt_count <= pkt_count + CNT_WIDTH'(1);
      if (state == ST_HDR) last_flow_id <= s_axis_tdata[35*8 +: 8];
      if (err_num != '0) begin
        err_count     <= err_count + CNT_WIDTH'(err_num);
        err_flag      <= 1'b1;
        last_err_code <= err_code;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_pkt_checker
// Purpose  : Self-checking bench for axis_pkt_checker. Packets are described
//            at packet level (configured length, actual beat count, length
//            field, first sequence word, corruptions) and a packet-level
//            reference model derives the expected statistics.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_checker;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  logic         cfg_enable;
  logic [15:0]  cfg_pkt_len;
  logic [63:0]  pkt_count;
  logic [63:0]  byte_count;
  logic [63:0]  err_count;
  logic         err_flag;
  logic [2:0]   last_err_code;
  logic [7:0]   last_flow_id;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [63:0] m_pkt, m_bytes, m_err, m_exp;
  logic        m_flag, m_locked;
  logic [2:0]  m_code;
  logic [7:0]  m_flow;

  always #5 clk = ~clk;

  axis_pkt_checker dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (tdata),
    .s_axis_tkeep  (tkeep),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tlast  (tlast),
    .cfg_enable    (cfg_enable),
    .cfg_pkt_len   (cfg_pkt_len),
    .pkt_count     (pkt_count),
    .byte_count    (byte_count),
    .err_count     (err_count),
    .err_flag      (err_flag),
    .last_err_code (last_err_code),
    .last_flow_id  (last_flow_id)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pkt = 0; m_bytes = 0; m_err = 0; m_exp = 64'd1;
    m_flag = 1'b0; m_locked = 1'b0; m_code = 3'd0; m_flow = 8'd0;
  endtask

  task automatic check_all(input string tag);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_pkt"},   pkt_count,     m_pkt);
    check({tag, "_bytes"}, byte_count,    m_bytes);
    check({tag, "_err"},   err_count,     m_err);
    check({tag, "_flag"},  64'(err_flag), 64'(m_flag));
    check({tag, "_code"},  64'(last_err_code), 64'(m_code));
    check({tag, "_flow"},  64'(last_flow_id),  64'(m_flow));
  endtask

  // Drive one beat and return just after the edge on which it was accepted.
  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    int guard;
    guard = 0;
    @(negedge clk);
    tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
    while (!tready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    compared++;
    assert (guard < 2000) else begin
      mismatched++;
      $error("FAIL ready_timeout observed=%0d expected<%0d", guard, 2000);
    end
    @(posedge clk);
    #1 tvalid = 1'b0;
  endtask

  task automatic stall();
    @(negedge clk);
    cfg_enable = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_ready", 64'(tready), 64'd0);
    cfg_enable = 1'b1;
  endtask

  // n beats, tlast on the final one. Body beat i carries w1+(i-1) unless it is
  // bad_beat (data 0). badkeep_beat gets a partial tkeep. stall_at pauses the
  // stream with cfg_enable low before that beat.
  task automatic run_pkt(input int lcfg, input int n, input logic [15:0] lenf,
                         input logic [63:0] w1, input int bad_beat,
                         input int badkeep_beat, input int stall_at);
    int L;
    logic [511:0] d;
    logic [63:0]  k, w;
    logic [6:0]   mask;
    logic [7:0]   flow;
    L = (lcfg == 0) ? 1 : lcfg;
    cfg_pkt_len = 16'(lcfg);
    flow = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) stall();
      mask = '0;
      k    = '1;
      if (i == 0) begin
        for (int x = 0; x < 16; x++) d[x*32 +: 32] = $urandom;
        d[16*8 +: 8] = lenf[15:8];
        d[17*8 +: 8] = lenf[7:0];
        d[35*8 +: 8] = flow;
        if (lenf != 16'(L * 64 - 14)) mask[1] = 1'b1;
        if (L == 1 && n > 1) mask[6] = 1'b1;
        if (L > 1 && n == 1) mask[5] = 1'b1;
      end else begin
        w = (i == bad_beat) ? 64'd0 : w1 + 64'(i - 1);
        d = {448'd0, w};
        if (i == badkeep_beat) begin
          k = {$urandom, $urandom};
          if (k == '1) k[0] = 1'b0;
        end
        if (i < L) begin
          if (i == 1) begin
            if (!m_locked) begin
              m_exp = w - 64'd1;
              m_locked = 1'b1;
            end else if (w != m_exp + 64'd1) begin
              mask[2] = 1'b1;
              m_exp = w - 64'd1;
            end
          end else if (w != m_exp + 64'(i)) begin
            mask[3] = 1'b1;
          end
          if (k != '1) mask[4] = 1'b1;
          if (i < L - 1 && i == n - 1) mask[5] = 1'b1;
          if (i == L - 1 && n > L) mask[6] = 1'b1;
        end
      end
      send_beat(d, k, (i == n - 1));
      m_bytes = m_bytes + 64'($countones(k));
      m_err   = m_err + 64'($countones(mask));
      if (mask != '0) begin
        m_flag = 1'b1;
        for (int c = 1; c <= 6; c++) if (mask[c]) m_code = 3'(c);
      end
    end
    m_pkt  = m_pkt + 64'd1;
    m_exp  = m_exp + 64'd1;
    m_flow = flow;
  endtask

  initial begin
    logic [63:0] e0, e1;
    int lc, L, n, bb, bk, sa;
    logic [15:0] lf;
    logic [63:0] w1;

    rst = 1'b1; cfg_enable = 1'b0; cfg_pkt_len = 16'd1;
    tdata = '0; tkeep = '0; tvalid = 1'b0; tlast = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(tready), 64'd0);
    check_all("reset");
    rst = 1'b0;
    cfg_enable = 1'b1;

    // Ten single-beat packets
    for (int p = 0; p < 10; p++) run_pkt(1, 1, 16'd50, 64'd0, -1, -1, -1);
    check_all("len1");
    check("len1_pkt10", pkt_count, 64'd10);
    check("len1_bytes640", byte_count, 64'd640);
    check("len1_noerr", err_count, 64'd0);

    // Five 4-beat packets with data k+i
    e0 = byte_count;
    for (int p = 1; p <= 5; p++) run_pkt(4, 4, 16'd242, 64'(p + 1), -1, -1, -1);
    check_all("len4");
    check("len4_bytes1280", byte_count - e0, 64'd1280);
    check("len4_flag", 64'(err_flag), 64'd0);

    // Payload corruption on packet 3 beat 2
    for (int p = 1; p <= 4; p++) begin
      run_pkt(4, 4, 16'd242, m_exp + 64'd1, (p == 3) ? 2 : -1, -1, -1);
      check_all("corrupt");
    end
    check("corrupt_cnt", err_count, 64'd1);
    check("corrupt_code", 64'(last_err_code), 64'd3);

    // Early tlast on beat 1, then a clean packet
    run_pkt(4, 2, 16'd242, m_exp + 64'd1, -1, -1, -1);
    check_all("early");
    check("early_code", 64'(last_err_code), 64'd5);
    e0 = err_count;
    run_pkt(4, 4, 16'd242, m_exp + 64'd1, -1, -1, -1);
    check_all("early_next");
    check("early_next_noerr", err_count, e0);

    // Overlong packet drains; bad tkeep inside the drained region is ignored
    e0 = byte_count; e1 = pkt_count;
    run_pkt(2, 5, 16'd114, m_exp + 64'd1, -1, -1, -1);
    check_all("drain");
    check("drain_bytes", byte_count - e0, 64'd320);
    check("drain_pkt", pkt_count - e1, 64'd1);
    check("drain_code", 64'(last_err_code), 64'd6);
    run_pkt(2, 4, 16'd114, m_exp + 64'd1, -1, 3, -1);
    check_all("drain_keep");

    // Body tkeep error, then two codes on one header beat
    run_pkt(3, 3, 16'd178, m_exp + 64'd1, -1, 2, -1);
    check_all("keep");
    e0 = err_count;
    run_pkt(1, 2, 16'd99, 64'd0, -1, -1, -1);
    check_all("multi");
    check("multi_cnt", err_count - e0, 64'd2);
    run_pkt(0, 1, 16'd50, 64'd0, -1, -1, -1);
    check_all("len0");

    // Sequence gap: packets 1, 3, 4
    e0 = err_count;
    run_pkt(4, 4, 16'd242, m_exp + 64'd1, -1, -1, -1);
    run_pkt(4, 4, 16'd242, m_exp + 64'd2, -1, -1, -1);
    check_all("skip");
    check("skip_code", 64'(last_err_code), 64'd2);
    run_pkt(4, 4, 16'd242, m_exp + 64'd1, -1, -1, -1);
    check_all("skip_next");
    check("skip_cnt", err_count - e0, 64'd1);

    // Stall mid-packet via cfg_enable
    run_pkt(4, 4, 16'd242, m_exp + 64'd1, -1, -1, 2);
    check_all("stall");

    // Reset mid-packet, then relock on an arbitrary sequence
    cfg_pkt_len = 16'd4;
    send_beat({448'd0, 64'h00f2_0000_0000_0000}, '1, 1'b0);
    send_beat({448'd0, m_exp + 64'd1}, '1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    check("midrst_ready", 64'(tready), 64'd0);
    check_all("midrst");
    rst = 1'b0;
    run_pkt(4, 4, 16'd242, {$urandom, $urandom}, -1, -1, -1);
    check_all("relock");
    check("relock_noerr", err_count, 64'd0);

    // Randomized packets
    for (int r = 0; r < 30; r++) begin
      lc = $urandom_range(0, 5);
      L  = (lc == 0) ? 1 : lc;
      case ($urandom_range(0, 5))
        0:       n = L + $urandom_range(1, 3);
        1:       n = $urandom_range(1, L);
        default: n = L;
      endcase
      lf = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'(L * 64 - 14);
      w1 = ($urandom_range(0, 5) == 0) ? {$urandom, $urandom} : m_exp + 64'd1;
      bb = (n > 2 && $urandom_range(0, 5) == 0) ? $urandom_range(2, n - 1) : -1;
      bk = (n > 1 && $urandom_range(0, 5) == 0) ? $urandom_range(1, n - 1) : -1;
      sa = (n > 1 && $urandom_range(0, 7) == 0) ? $urandom_range(1, n - 1) : -1;
      run_pkt(lc, n, lf, w1, bb, bk, sa);
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_pkt_checker.md
Name: axis_pkt_checker

Overview:
- Synthesizable AXIS receive-side checker on the panic m_rx_axis output; it is the consuming end of the packet generator's stream.
- Accepts 512-bit beats and checks the UDP header length field, the per-packet sequence, the payload pattern, tkeep and tlast framing.
- Accumulates packet, byte and error statistics for on-board or cocotb readout.

Parameters:
AXIS_DATA_WIDTH, 512, stream data width in bits
AXIS_KEEP_WIDTH, 64, AXIS_DATA_WIDTH/8
CNT_WIDTH, 64, width of statistics counters and sequence/pattern arithmetic
LEN_WIDTH, 16, width of cfg_pkt_len (beats per packet)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axis_tdata  in  AXIS_DATA_WIDTH  stream data
s_axis_tkeep  in  AXIS_KEEP_WIDTH  byte enables
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  beat ready
s_axis_tlast  in  1  last beat of packet
cfg_enable  in  1  1 = accept and check; 0 = tready low
cfg_pkt_len  in  LEN_WIDTH  expected beats per packet; 0 is treated as 1
pkt_count  out  CNT_WIDTH  packets accepted (tlast beats)
byte_count  out  CNT_WIDTH  sum of popcount(tkeep) over accepted beats
err_count  out  CNT_WIDTH  total errors detected, wraps
err_flag  out  1  sticky; set on first error, cleared only by rst
last_err_code  out  3  code of most recent error
last_flow_id  out  8  byte 35 of the last accepted header beat

Behaviour:
- Reset (clk edge with rst=1): all counters 0; err_flag 0; last_err_code 0; last_flow_id 0; state HDR; beat_idx 0; exp_seq 1; seq_locked 0; s_axis_tready 0. A reset mid-packet discards the partial packet.
- Ready:
  - s_axis_tready = cfg_enable, registered, so it goes high on the cycle after cfg_enable rises.
  - A beat is accepted when tvalid && tready.
  - Dropping cfg_enable mid-packet only stalls the stream; checker state is kept.
- Packet start: at each header beat, latch len_q = max(cfg_pkt_len, 1).
- States: HDR, BODY, DRAIN.
- HDR (beat_idx 0), on accept:
  - Check {tdata[16*8+:8], tdata[17*8+:8]} == len_q*64-14 (16-bit, modulo). Mismatch → code 1.
  - Latch last_flow_id = tdata[35*8+:8].
  - If len_q == 1: tlast must be 1, else code 6 and go to DRAIN. Otherwise tlast=1 is code 5, end of packet.
  - If len_q > 1 and tlast=0: go to BODY.
- BODY, beat i (1..len_q-1):
  - Expected value E = exp_seq + i, zero-extended to AXIS_DATA_WIDTH.
  - At beat 1, if seq_locked=0: adopt exp_seq = tdata[CNT_WIDTH-1:0]-1 and set seq_locked. No error.
  - At beat 1, if seq_locked=1 and tdata != E: code 2, resync exp_seq = tdata-1.
  - At beats ≥2: tdata != E is code 3.
  - tkeep != all-ones is code 4 at any beat, checked independently.
  - tlast at i < len_q-1 is code 5; the packet ends and the state returns to HDR.
  - No tlast at i == len_q-1 is code 6; go to DRAIN.
- DRAIN: accept and discard beats (byte_count still counts them) until tlast, then go to HDR. No further error codes are raised in DRAIN.
- End of packet (any accepted tlast):
  - pkt_count+1.
  - exp_seq+1, applied after any resync from the same packet.
  - beat_idx reset to 0.
- Multiple errors on one beat: err_count adds the number of distinct codes raised. last_err_code takes the highest code.
- Statistics and error outputs are registered, visible 1 cycle after the accepting edge.
- All counters wrap modulo 2^CNT_WIDTH.

Optional Feature:
- Macro AXIS_PKT_CHECKER_BACKPRESSURE_EN.
- Defined: a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every cycle. s_axis_tready = cfg_enable && (lfsr[6:0] < 100), giving ~78% ready duty, to exercise upstream backpressure.
- Not defined: tready follows cfg_enable only; no LFSR logic.

Test Plan:
- cfg_pkt_len=1, ten correct 64B header packets with length field 50 → pkt_count=10, byte_count=640, err_count=0.
- cfg_pkt_len=4, packets k=1..5, beat i data k+i, length field 242 → pkt_count=5, byte_count=1280, err_flag=0.
- cfg_pkt_len=4, packet 3 beat 2 data corrupted to 0 → err_count=1, last_err_code=3; packet 4 passes clean.
- cfg_pkt_len=4, tlast asserted on beat 1 → last_err_code=5; next correct 4-beat packet gives no error.
- cfg_pkt_len=2, 5-beat packet → code 6, DRAIN absorbs 3 beats, byte_count +320, pkt_count +1.
- Packet 2 skipped (packets 1,3,4) → code 2 on packet 3, resync, packet 4 clean, err_count=1; rst asserted mid-packet → all outputs 0, next packet relocks seq with no error.
